// File: rtl/dbnc_pkg.sv
// Shared types and constants for the input debouncer: FSM state encoding and command width.
package dbnc_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CHANGED = 2'b01,
        COMMIT  = 2'b10
    } state_t;

endpackage : dbnc_pkg

// File: rtl/input_debounce_sync_chain.sv
// Multi-bit, multi-stage synchronizer bringing asynchronous levels into the clk domain.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    // NOTE: non-blocking shift, so each stage captures its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : sync_chain

// File: rtl/input_debounce.sv
// Debounces a 3-bit button/switch bus into registered commands with a one-cycle valid pulse.
// Optional DBNC_FSM_CHECK_EN makes illegal FSM encodings raise a sticky fsm_fault flag.
module input_debounce
    import dbnc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] raw_in,
    output logic [CMD_W-1:0] user_input,
    output logic             cmd_valid,
    output logic             fsm_fault
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [CMD_W-1:0] w_sample;
    state_t           r_state;
    logic [CMD_W-1:0] r_cand;
    logic [7:0]       r_cnt;
    logic [CMD_W-1:0] r_user_input;
    logic             r_cmd_valid;
`ifdef DBNC_FSM_CHECK_EN
    logic             r_fsm_fault;
`endif

    sync_chain #(
        .WIDTH  (CMD_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (raw_in),
        .o_q   (w_sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_user_input <= '0;
            r_cmd_valid  <= 1'b0;
`ifdef DBNC_FSM_CHECK_EN
            r_fsm_fault  <= 1'b0;
`endif
        end else begin
            r_cmd_valid <= 1'b0;
            // NOTE: default arm catches the unused encoding so a corrupted state always returns to IDLE.
            case (r_state)
                IDLE: begin
                    if (w_sample != r_user_input) begin
                        r_state <= CHANGED;
                        r_cand  <= w_sample;
                        r_cnt   <= 8'd1;
                    end
                end
                CHANGED: begin
                    if (w_sample == r_user_input) begin
                        r_state <= IDLE;
                    end else if (w_sample != r_cand) begin
                        r_cand <= w_sample;
                        r_cnt  <= 8'd1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                COMMIT: begin
                    r_user_input <= r_cand;
                    r_cmd_valid  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
`ifdef DBNC_FSM_CHECK_EN
                    r_fsm_fault <= 1'b1;
`endif
                end
            endcase
        end
    end

    assign user_input = r_user_input;
    assign cmd_valid  = r_cmd_valid;
`ifdef DBNC_FSM_CHECK_EN
    assign fsm_fault  = r_fsm_fault;
`else
    assign fsm_fault  = 1'b0;
`endif

endmodule : input_debounce

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: table-driven latency vectors plus hand-written corner sequences.
module tb_input_debounce;
    import dbnc_pkg::*;

`ifdef DBNC_FSM_CHECK_EN
    localparam logic EXP_FAULT = 1'b1;
`else
    localparam logic EXP_FAULT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] raw_in;
    logic [2:0] user_input;
    logic       cmd_valid;
    logic       fsm_fault;
    logic [2:0] raw_in2;
    logic [2:0] user_input2;
    logic       cmd_valid2;
    logic       fsm_fault2;

    int n_total = 0;
    int n_pass  = 0;

    input_debounce dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .user_input (user_input),
        .cmd_valid  (cmd_valid),
        .fsm_fault  (fsm_fault)
    );

    input_debounce #(
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (2)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in2),
        .user_input (user_input2),
        .cmd_valid  (cmd_valid2),
        .fsm_fault  (fsm_fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_rst;
        logic [2:0] raw;
        logic [2:0] exp_ui;
        logic       exp_cv;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add_vec(input logic do_rst, input logic [2:0] raw,
                           input logic [2:0] exp_ui, input logic exp_cv);
        vec_t v;
        v.do_rst = do_rst;
        v.raw    = raw;
        v.exp_ui = exp_ui;
        v.exp_cv = exp_cv;
        vecs.push_back(v);
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        raw_in  = 3'b000;
        raw_in2 = 3'b000;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ui", 32'(user_input), 32'h0);
        check("rst_cv", 32'(cmd_valid), 32'h0);
        check("rst_fault", 32'(fsm_fault), 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b1;
        raw_in  = 3'b000;
        raw_in2 = 3'b000;

        // 3'b101 held: commit exactly at edge 7, never again.
        add_vec(1'b1, 3'b101, 3'b000, 1'b0);
        for (int k = 2; k <= 6; k++) add_vec(1'b0, 3'b101, 3'b000, 1'b0);
        add_vec(1'b0, 3'b101, 3'b101, 1'b1);
        for (int k = 8; k <= 12; k++) add_vec(1'b0, 3'b101, 3'b101, 1'b0);
        // 3'b001 for 2 cycles then 3'b011: a single commit of 3'b011 at edge 9.
        add_vec(1'b1, 3'b001, 3'b000, 1'b0);
        add_vec(1'b0, 3'b001, 3'b000, 1'b0);
        for (int k = 3; k <= 8; k++) add_vec(1'b0, 3'b011, 3'b000, 1'b0);
        add_vec(1'b0, 3'b011, 3'b011, 1'b1);
        for (int k = 10; k <= 13; k++) add_vec(1'b0, 3'b011, 3'b011, 1'b0);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            raw_in = vecs[i].raw;
            step();
            check($sformatf("vec%0d_ui", i), 32'(user_input), 32'(vecs[i].exp_ui));
            check($sformatf("vec%0d_cv", i), 32'(cmd_valid), 32'(vecs[i].exp_cv));
        end

        // Bouncing 000<->010 every 2 cycles for 40 cycles must never commit.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            raw_in = ((c % 4) < 2) ? 3'b010 : 3'b000;
            step();
            check($sformatf("bounce%0d_ui", c), 32'(user_input), 32'h0);
            check($sformatf("bounce%0d_cv", c), 32'(cmd_valid), 32'h0);
        end
        repeat (8) step();
        check("bounce_end_ui", 32'(user_input), 32'h0);

        // Reset mid-debounce of 3'b111 from a committed 3'b101.
        do_reset();
        raw_in = 3'b101;
        repeat (10) step();
        check("pre_ui", 32'(user_input), 32'h5);
        raw_in = 3'b111;
        repeat (4) step();
        check("mid_state", 32'(dut.r_state), 32'(CHANGED));
        check("mid_cnt", 32'(dut.r_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async_ui", 32'(user_input), 32'h0);
        check("async_cv", 32'(cmd_valid), 32'h0);
        check("async_state", 32'(dut.r_state), 32'(IDLE));
        check("async_cnt", 32'(dut.r_cnt), 32'd0);
        check("async_cand", 32'(dut.r_cand), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("redeb%0d_ui", k), 32'(user_input), (k >= 7) ? 32'h7 : 32'h0);
            check($sformatf("redeb%0d_cv", k), 32'(cmd_valid), (k == 7) ? 32'h1 : 32'h0);
        end

        // Illegal state 2'b11 recovers to IDLE with cnt cleared.
        check("pre_fault_cnt", 32'(dut.r_cnt), 32'd3);
        force dut.r_state = state_t'(2'b11);
        #1;
        release dut.r_state;
        step();
        check("illegal_state", 32'(dut.r_state), 32'(IDLE));
        check("illegal_cnt", 32'(dut.r_cnt), 32'd0);
        check("illegal_fault", 32'(fsm_fault), 32'(EXP_FAULT));
        check("illegal_ui", 32'(user_input), 32'h7);
        repeat (5) step();
        check("fault_sticky", 32'(fsm_fault), 32'(EXP_FAULT));
        check("fault_no_pulse", 32'(cmd_valid), 32'h0);
        do_reset();
        check("fault_cleared", 32'(fsm_fault), 32'h0);

        // SYNC_STAGES=3, DEBOUNCE_CYCLES=2: update at edge 6.
        raw_in2 = 3'b100;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("p2_%0d_ui", k), 32'(user_input2), (k >= 6) ? 32'h4 : 32'h0);
            check($sformatf("p2_%0d_cv", k), 32'(cmd_valid2), (k == 6) ? 32'h1 : 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_input_debounce

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops per input bit (legal values 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive equal samples required to accept a change (legal values 2..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops use the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port raw_in, input, 3 bits: asynchronous button/switch levels.
REQ-006 SHALL have port user_input, output, 3 bits: debounced command, registered, feeding the downstream fsm.
REQ-007 SHALL have port cmd_valid, output, 1 bit: one-cycle pulse coincident with each user_input update.
REQ-008 SHALL have port fsm_fault, output, 1 bit: sticky illegal-state flag.

Function
REQ-009 SHALL pass each raw_in bit through SYNC_STAGES flops; the last stage is the sample s.
REQ-010 SHALL implement a 3-state FSM: IDLE, CHANGED and COMMIT, using registers state, cand[2:0] and cnt[7:0].
REQ-011 In IDLE, if s != user_input, the FSM SHALL move to CHANGED with cand<=s and cnt<=1; otherwise it SHALL hold.
REQ-012 In CHANGED, if s == user_input (bounce back), the FSM SHALL move to IDLE without updating user_input and without a pulse.
REQ-013 In CHANGED, if s differs from both cand and user_input, the FSM SHALL load cand<=s and cnt<=1 (restart counting).
REQ-014 In CHANGED, if s == cand, the FSM SHALL increment cnt; when cnt == DEBOUNCE_CYCLES-1 it SHALL move to COMMIT.
REQ-015 In COMMIT, the FSM SHALL update user_input<=cand, assert cmd_valid for exactly one cycle, and return to IDLE unconditionally.
REQ-016 Latency SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges from a stable raw_in change to the user_input update (7 with defaults).
REQ-017 In IDLE and CHANGED, cmd_valid SHALL be 0; user_input SHALL change only in COMMIT.
REQ-018 cnt SHALL never wrap: it saturates at DEBOUNCE_CYCLES-1 by construction, because COMMIT is always taken.
REQ-019 A raw_in change occurring during COMMIT SHALL be handled from the following IDLE cycle.

Reset
REQ-020 Assertion of rst_n low SHALL immediately clear the synchronizer flops, user_input=3'b000, cmd_valid=0, fsm_fault=0, state=IDLE, cand=0 and cnt=0.
REQ-021 Reset asserted mid-debounce SHALL discard cand and cnt; no pulse SHALL be produced on release.
REQ-022 After rst_n deassertion, the first possible cmd_valid SHALL occur no earlier than the REQ-016 latency.

Configuration
REQ-023 With DBNC_FSM_CHECK_EN defined, any state encoding outside the three legal states SHALL force state=IDLE with cnt=0 on the next edge and SHALL set fsm_fault, which stays high until reset.
REQ-024 Without DBNC_FSM_CHECK_EN, illegal states SHALL still recover to IDLE, and fsm_fault SHALL be tied to 0.

Structure
REQ-025 Package dbnc_pkg SHALL hold the state enum typedef (IDLE, CHANGED, COMMIT on 2 bits) and the constant CMD_W=3.
REQ-026 The synchronizer chain SHALL be a sub-module sync_chain, parameterized by width and stage count and instantiated once.

Verification
REQ-027 The bench SHALL cover: reset, then raw_in=3'b101 held -> user_input=3'b101 and cmd_valid pulses exactly at edge 7 and never again.
REQ-028 The bench SHALL cover: raw_in toggling 3'b000<->3'b010 every 2 cycles for 40 cycles -> user_input stays 3'b000 and cmd_valid stays 0.
REQ-029 The bench SHALL cover: raw_in=3'b001 for 2 cycles, then 3'b011 held -> a single commit of 3'b011, with no intermediate 3'b001.
REQ-030 The bench SHALL cover: rst_n pulsed low 2 cycles into a debounce of 3'b111 -> outputs go to 0 immediately and no pulse follows; re-debounce then takes 7 cycles.
REQ-031 The bench SHALL cover, with DBNC_FSM_CHECK_EN, forcing state to 2'b11 -> next edge state=IDLE and fsm_fault=1 until reset; without the macro, fsm_fault stays 0.
REQ-032 The bench SHALL cover: DEBOUNCE_CYCLES=2 and SYNC_STAGES=3 with raw_in=3'b100 -> update at edge 6.
